alu_issue_seq: RTL and testbench

- Operand-issue sequencer directly upstream of the 4-bit ALU.
- Holds a small register file and accepts one instruction at a time through a valid/ready handshake.
- Drives the ALU's x, y and op inputs, captures the ALU's out/cout, and writes the result back to the register file.
- Turns the combinational ALU into a clocked, multi-instruction datapath.

---
 rtl/alu_issue_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_issue_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// Operand-issue sequencer for the 4-bit ALU: register file, IDLE/EXEC/WB issue FSM, write-back.
// Optional load-immediate opcode (op 4'hF) enabled by defining ALU_ISSUE_LOADI_EN.
module alu_issue_seq #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREG  = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [4+3*AW-1:0] instr,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    output logic             wb_valid,
    output logic [AW-1:0]    wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             flag_c,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] rf_d [NREG];
    logic [WIDTH-1:0] alu_x_q, alu_x_d;
    logic [WIDTH-1:0] alu_y_q, alu_y_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic             wb_valid_q, wb_valid_d;
    logic [AW-1:0]    wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             flag_c_q, flag_c_d;

    logic [3:0]    dec_op;
    logic [AW-1:0] dec_rd, dec_rs1, dec_rs2;

    assign dec_op  = instr[4+3*AW-1 -: 4];
    assign dec_rd  = instr[3*AW-1 -: AW];
    assign dec_rs1 = instr[2*AW-1 -: AW];
    assign dec_rs2 = instr[AW-1:0];

`ifdef ALU_ISSUE_LOADI_EN
    logic             loadi_q, loadi_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] dec_imm;
    logic [2*AW-1:0]  dec_imm_raw;

    assign dec_imm_raw = {dec_rs1, dec_rs2};

    // Immediate {rs1, rs2} is zero-extended or truncated to the datapath width.
    if (2 * AW >= WIDTH) begin : g_imm_trunc
        assign dec_imm = dec_imm_raw[WIDTH-1:0];
    end else begin : g_imm_ext
        assign dec_imm = {{(WIDTH - 2 * AW){1'b0}}, dec_imm_raw};
    end
`endif

    always_comb begin
        state_d    = state_q;
        rf_d       = rf_q;
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        alu_op_d   = alu_op_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        flag_c_d   = flag_c_q;
`ifdef ALU_ISSUE_LOADI_EN
        loadi_d    = loadi_q;
        imm_d      = imm_q;
`endif
        unique case (state_q)
            StIdle: begin
                // An accepted instruction (including NOP) always wins over a preload write.
                if (instr_valid) begin
                    if (dec_op != 4'h0) begin
                        rd_d    = dec_rd;
                        state_d = StExec;
`ifdef ALU_ISSUE_LOADI_EN
                        loadi_d = (dec_op == 4'hF);
                        imm_d   = dec_imm;
                        if (dec_op == 4'hF) begin
                            alu_op_d = 4'h0;
                        end else begin
                            alu_x_d  = rf_q[dec_rs1];
                            alu_y_d  = rf_q[dec_rs2];
                            alu_op_d = dec_op;
                        end
`else
                        alu_x_d  = rf_q[dec_rs1];
                        alu_y_d  = rf_q[dec_rs2];
                        alu_op_d = dec_op;
`endif
                    end
                end else if (cfg_we) begin
                    rf_d[cfg_addr] = cfg_data;
                end
            end
            StExec: begin
                wb_valid_d = 1'b1;
                wb_addr_d  = rd_q;
                state_d    = StWb;
`ifdef ALU_ISSUE_LOADI_EN
                if (loadi_q) begin
                    rf_d[rd_q] = imm_q;
                    wb_data_d  = imm_q;
                end else begin
                    rf_d[rd_q] = alu_out;
                    wb_data_d  = alu_out;
                    flag_c_d   = alu_cout;
                end
`else
                rf_d[rd_q] = alu_out;
                wb_data_d  = alu_out;
                flag_c_d   = alu_cout;
`endif
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rf_q       <= '{default: '0};
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            alu_op_q   <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            flag_c_q   <= 1'b0;
`ifdef ALU_ISSUE_LOADI_EN
            loadi_q    <= 1'b0;
            imm_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rf_q       <= rf_d;
            alu_x_q    <= alu_x_d;
            alu_y_q    <= alu_y_d;
            alu_op_q   <= alu_op_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            flag_c_q   <= flag_c_d;
`ifdef ALU_ISSUE_LOADI_EN
            loadi_q    <= loadi_d;
            imm_q      <= imm_d;
`endif
        end
    end

    assign instr_ready = (state_q == StIdle);
    assign busy        = ~instr_ready;
    assign alu_x       = alu_x_q;
    assign alu_y       = alu_y_q;
    assign alu_op      = alu_op_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign flag_c      = flag_c_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a small behavioural ALU (1 = add, 2 = subtract, else xor).
// Honours ALU_ISSUE_LOADI_EN for the load-immediate scenario.
module tb_alu_issue_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [9:0] instr = '0;
    logic [3:0] alu_x, alu_y, alu_op, alu_out;
    logic       alu_cout;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [3:0] cfg_data = '0;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [3:0] wb_data;
    logic       flag_c;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            4'h1:    {alu_cout, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
            4'h2:    {alu_cout, alu_out} = {1'b0, alu_x} + {1'b0, ~alu_y} + 5'd1;
            default: {alu_cout, alu_out} = {1'b0, alu_x ^ alu_y};
        endcase
    end

    alu_issue_seq dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_cout   (alu_cout),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flag_c     (flag_c),
        .busy       (busy)
    );

    task automatic preload(input logic [1:0] addr, input logic [3:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Presents one instruction and returns on the negedge inside EXEC.
    task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2);
        @(negedge clk);
        instr_valid = 1'b1; instr = {op, rd, rs1, rs2};
        @(negedge clk);
        instr_valid = 1'b0; instr = 10'h3FF;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({alu_x, alu_y, alu_op, wb_valid, wb_addr, wb_data, flag_c, busy, instr_ready} !==
            {4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_outputs: got x=%0d y=%0d op=%0d wbv=%0b wba=%0d wbd=%0d c=%0b busy=%0b rdy=%0b, want zeros with rdy=1",
                     alu_x, alu_y, alu_op, wb_valid, wb_addr, wb_data, flag_c, busy, instr_ready);
        end
    endtask

    task automatic test_add;
        preload(2'd1, 4'd6);
        preload(2'd2, 4'd3);
        send(4'h1, 2'd3, 2'd1, 2'd2);
        vectors++;
        if ({alu_x, alu_y, alu_op, instr_ready, busy} !== {4'd6, 4'd3, 4'd1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL add_exec: got x=%0d y=%0d op=%0d rdy=%0b busy=%0b, want 6 3 1 0 1",
                     alu_x, alu_y, alu_op, instr_ready, busy);
        end
        @(negedge clk);
        vectors++;
        if ({wb_valid, wb_addr, wb_data, flag_c, instr_ready} !== {1'b1, 2'd3, 4'd9, 1'b0, 1'b0})
        begin
            miscompares++;
            $display("FAIL add_wb: got wbv=%0b wba=%0d wbd=%0d c=%0b rdy=%0b, want 1 3 9 0 0",
                     wb_valid, wb_addr, wb_data, flag_c, instr_ready);
        end
        @(negedge clk);
        vectors++;
        if ({wb_valid, instr_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL add_done: got wbv=%0b rdy=%0b, want 0 1", wb_valid, instr_ready);
        end
    endtask

    task automatic test_carry;
        preload(2'd1, 4'd12);
        preload(2'd2, 4'd5);
        send(4'h1, 2'd0, 2'd1, 2'd2);
        @(negedge clk);
        vectors++;
        if ({wb_valid, wb_addr, wb_data, flag_c} !== {1'b1, 2'd0, 4'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL carry_wb: got wbv=%0b wba=%0d wbd=%0d c=%0b, want 1 0 1 1",
                     wb_valid, wb_addr, wb_data, flag_c);
        end
        @(negedge clk);
        instr_valid = 1'b1; instr = {4'h0, 2'd3, 2'd2, 2'd1};
        @(negedge clk);
        instr_valid = 1'b0;
        vectors++;
        if ({instr_ready, wb_valid, flag_c, alu_op} !== {1'b1, 1'b0, 1'b1, 4'd1}) begin
            miscompares++;
            $display("FAIL nop_hold: got rdy=%0b wbv=%0b c=%0b op=%0d, want 1 0 1 1",
                     instr_ready, wb_valid, flag_c, alu_op);
        end
        @(negedge clk);
        vectors++;
        if (wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL nop_no_wb: got wbv=%0b, want 0", wb_valid);
        end
    endtask

    task automatic test_back_to_back;
        preload(2'd1, 4'd6);
        preload(2'd2, 4'd3);
        @(negedge clk);
        instr_valid = 1'b1; instr = {4'h1, 2'd1, 2'd1, 2'd2};
        @(negedge clk);
        instr = {4'h2, 2'd2, 2'd1, 2'd2};
        vectors++;
        if ({alu_x, alu_y, instr_ready} !== {4'd6, 4'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_first_exec: got x=%0d y=%0d rdy=%0b, want 6 3 0",
                     alu_x, alu_y, instr_ready);
        end
        @(negedge clk);
        vectors++;
        if ({instr_ready, wb_data} !== {1'b0, 4'd9}) begin
            miscompares++;
            $display("FAIL b2b_first_wb: got rdy=%0b wbd=%0d, want 0 9", instr_ready, wb_data);
        end
        @(negedge clk);
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready_gap: got rdy=%0b, want 1", instr_ready);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        vectors++;
        if ({alu_x, alu_y, alu_op, instr_ready} !== {4'd9, 4'd3, 4'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_second_exec: got x=%0d y=%0d op=%0d rdy=%0b, want 9 3 2 0",
                     alu_x, alu_y, alu_op, instr_ready);
        end
        @(negedge clk);
        vectors++;
        if ({wb_valid, wb_addr, wb_data} !== {1'b1, 2'd2, 4'd6}) begin
            miscompares++;
            $display("FAIL b2b_second_wb: got wbv=%0b wba=%0d wbd=%0d, want 1 2 6",
                     wb_valid, wb_addr, wb_data);
        end
        @(negedge clk);
        send(4'h1, 2'd3, 2'd2, 2'd1);
        vectors++;
        if ({alu_x, alu_y} !== {4'd6, 4'd9}) begin
            miscompares++;
            $display("FAIL b2b_readback: got x=%0d y=%0d, want 6 9", alu_x, alu_y);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cfg_rules;
        preload(2'd0, 4'd5);
        vectors++;
        if ({wb_valid, instr_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL cfg_no_wb: got wbv=%0b rdy=%0b, want 0 1", wb_valid, instr_ready);
        end
        @(negedge clk);
        instr_valid = 1'b1; instr = {4'h1, 2'd1, 2'd2, 2'd2};
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 4'd15;
        @(negedge clk);
        instr_valid = 1'b0; cfg_data = 4'd14;
        repeat (2) @(negedge clk);
        cfg_we = 1'b0;
        send(4'h1, 2'd3, 2'd0, 2'd0);
        vectors++;
        if (alu_x !== 4'd5) begin
            miscompares++;
            $display("FAIL cfg_dropped: got R0=%0d, want 5", alu_x);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        send(4'h1, 2'd1, 2'd1, 2'd1);
        rst = 1'b1;
        #1;
        vectors++;
        if ({instr_ready, busy, alu_x, alu_y, alu_op, flag_c} !==
            {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_async: got rdy=%0b busy=%0b x=%0d y=%0d op=%0d c=%0b, want 1 0 0 0 0 0",
                     instr_ready, busy, alu_x, alu_y, alu_op, flag_c);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (wb_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_no_wb: cycle %0d got wbv=%0b, want 0", i, wb_valid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            send(4'h1, 2'(i), 2'(i), 2'(i));
            vectors++;
            if ({alu_x, alu_y} !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_mid_reg%0d: got x=%0d y=%0d, want 0 0", i, alu_x, alu_y);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_loadi;
        send(4'hF, 2'd2, 2'b10, 2'b11);
`ifdef ALU_ISSUE_LOADI_EN
        vectors++;
        if ({alu_op, alu_x, alu_y} !== {4'd0, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL loadi_exec: got op=%0d x=%0d y=%0d, want 0 0 0", alu_op, alu_x, alu_y);
        end
        @(negedge clk);
        vectors++;
        if ({wb_valid, wb_addr, wb_data, flag_c} !== {1'b1, 2'd2, 4'd11, 1'b0}) begin
            miscompares++;
            $display("FAIL loadi_wb: got wbv=%0b wba=%0d wbd=%0d c=%0b, want 1 2 11 0",
                     wb_valid, wb_addr, wb_data, flag_c);
        end
        @(negedge clk);
        send(4'h1, 2'd3, 2'd2, 2'd0);
        vectors++;
        if (alu_x !== 4'd11) begin
            miscompares++;
            $display("FAIL loadi_readback: got R2=%0d, want 11", alu_x);
        end
`else
        vectors++;
        if ({alu_op, alu_x, alu_y} !== {4'hF, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL op_f_exec: got op=%0d x=%0d y=%0d, want 15 0 0", alu_op, alu_x, alu_y);
        end
        @(negedge clk);
        vectors++;
        if ({wb_valid, wb_addr, wb_data} !== {1'b1, 2'd2, 4'd0}) begin
            miscompares++;
            $display("FAIL op_f_wb: got wbv=%0b wba=%0d wbd=%0d, want 1 2 0",
                     wb_valid, wb_addr, wb_data);
        end
        @(negedge clk);
`endif
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_back_to_back();
        test_cfg_rules();
        test_reset_mid();
        test_loadi();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
